// File: rtl/qpu_dtcm_icb_arbiter.sv
// qpu_dtcm_icb_arbiter: shares the DTCM ICB port between EXU (m0) and loader (m1).
// Round-robin grant with stall lock; responses routed via an outstanding-index FIFO.
`ifndef QPU_ADDR_SIZE
`define QPU_ADDR_SIZE 32
`endif
`ifndef QPU_XLEN
`define QPU_XLEN 32
`endif

module qpu_dtcm_icb_arbiter #(
    parameter int AW         = `QPU_ADDR_SIZE,
    parameter int DW         = `QPU_XLEN,
    parameter int OUTS_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_icb_cmd_valid,
    output logic            m0_icb_cmd_ready,
    input  logic [AW-1:0]   m0_icb_cmd_addr,
    input  logic            m0_icb_cmd_read,
    input  logic [DW-1:0]   m0_icb_cmd_wdata,
    input  logic [DW/8-1:0] m0_icb_cmd_wmask,
    output logic            m0_icb_rsp_valid,
    input  logic            m0_icb_rsp_ready,
    output logic [DW-1:0]   m0_icb_rsp_rdata,
    output logic            m0_icb_rsp_err,

    input  logic            m1_icb_cmd_valid,
    output logic            m1_icb_cmd_ready,
    input  logic [AW-1:0]   m1_icb_cmd_addr,
    input  logic            m1_icb_cmd_read,
    input  logic [DW-1:0]   m1_icb_cmd_wdata,
    input  logic [DW/8-1:0] m1_icb_cmd_wmask,
    output logic            m1_icb_rsp_valid,
    input  logic            m1_icb_rsp_ready,
    output logic [DW-1:0]   m1_icb_rsp_rdata,
    output logic            m1_icb_rsp_err,

    output logic            s_icb_cmd_valid,
    input  logic            s_icb_cmd_ready,
    output logic [AW-1:0]   s_icb_cmd_addr,
    output logic            s_icb_cmd_read,
    output logic [DW-1:0]   s_icb_cmd_wdata,
    output logic [DW/8-1:0] s_icb_cmd_wmask,
    input  logic            s_icb_rsp_valid,
    output logic            s_icb_rsp_ready,
    input  logic [DW-1:0]   s_icb_rsp_rdata,
    input  logic            s_icb_rsp_err,

    output logic            arb_active
);

    localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int CW = $clog2(OUTS_DEPTH) + 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(OUTS_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OUTS_DEPTH);

    logic [OUTS_DEPTH-1:0] fifo_q, fifo_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rr_last_q, rr_last_d;
    logic                  lock_vld_q, lock_vld_d;
    logic                  lock_idx_q, lock_idx_d;

    logic sel, full, empty, head;
    logic cmd_hs, rsp_hs, lock_drop;

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rptr_q];

    // Grant choice: held lock first, then a lone requester, then round-robin
    always_comb begin
        sel = ~rr_last_q;
        if (lock_vld_q) begin
            sel = lock_idx_q;
        end else if (m0_icb_cmd_valid & ~m1_icb_cmd_valid) begin
            sel = 1'b0;
        end else if (m1_icb_cmd_valid & ~m0_icb_cmd_valid) begin
            sel = 1'b1;
        end
    end

    assign s_icb_cmd_valid = (m0_icb_cmd_valid | m1_icb_cmd_valid) & ~full;
    assign s_icb_cmd_addr  = sel ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_read  = sel ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_wdata = sel ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask = sel ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

    assign m0_icb_cmd_ready = ~sel & s_icb_cmd_ready & ~full;
    assign m1_icb_cmd_ready =  sel & s_icb_cmd_ready & ~full;

    assign cmd_hs = s_icb_cmd_valid & s_icb_cmd_ready;

    // Responses go to the requester at the FIFO head; data is fanned out
    assign m0_icb_rsp_valid = s_icb_rsp_valid & ~empty & ~head;
    assign m1_icb_rsp_valid = s_icb_rsp_valid & ~empty &  head;
    assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m0_icb_rsp_err   = s_icb_rsp_err;
    assign m1_icb_rsp_err   = s_icb_rsp_err;
    assign s_icb_rsp_ready  = ~empty & (head ? m1_icb_rsp_ready : m0_icb_rsp_ready);

    assign rsp_hs = s_icb_rsp_valid & s_icb_rsp_ready;

    assign arb_active = m0_icb_cmd_valid | m1_icb_cmd_valid | ~empty;

    // A locked requester that drops valid breaks the protocol; release its lock
    assign lock_drop = lock_vld_q & (lock_idx_q ? ~m1_icb_cmd_valid : ~m0_icb_cmd_valid);

    // Next state for the outstanding FIFO, round-robin pointer and stall lock
    always_comb begin
        fifo_d     = fifo_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        rr_last_d  = rr_last_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;

        if (cmd_hs) begin
            fifo_d[wptr_q] = sel;
            wptr_d         = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
            rr_last_d      = sel;
        end
        if (rsp_hs) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
        end

        unique case ({cmd_hs, rsp_hs})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (cmd_hs) begin
            lock_vld_d = 1'b0;
        end else if (lock_drop) begin
            lock_vld_d = 1'b0;
        end else if (s_icb_cmd_valid & ~s_icb_cmd_ready) begin
            lock_vld_d = 1'b1;
            lock_idx_d = sel;
        end
    end

    // State registers; reset empties the FIFO and gives m0 the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            rr_last_q  <= 1'b1;
            lock_vld_q <= 1'b0;
            lock_idx_q <= 1'b0;
        end else begin
            fifo_q     <= fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            rr_last_q  <= rr_last_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_qpu_dtcm_icb_arbiter.sv
// tb_qpu_dtcm_icb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based model of the arbiter.
module tb_qpu_dtcm_icb_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MW    = DW / 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
    logic [AW-1:0] m0_icb_cmd_addr;
    logic [DW-1:0] m0_icb_cmd_wdata, m0_icb_rsp_rdata;
    logic [MW-1:0] m0_icb_cmd_wmask;
    logic          m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;

    logic          m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
    logic [AW-1:0] m1_icb_cmd_addr;
    logic [DW-1:0] m1_icb_cmd_wdata, m1_icb_rsp_rdata;
    logic [MW-1:0] m1_icb_cmd_wmask;
    logic          m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;

    logic          s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
    logic [AW-1:0] s_icb_cmd_addr;
    logic [DW-1:0] s_icb_cmd_wdata, s_icb_rsp_rdata;
    logic [MW-1:0] s_icb_cmd_wmask;
    logic          s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
    logic          arb_active;

    int checks = 0;
    int errors = 0;

    qpu_dtcm_icb_arbiter #(.AW(AW), .DW(DW), .OUTS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
        .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
        .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
        .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
        .m0_icb_rsp_rdata(m0_icb_rsp_rdata), .m0_icb_rsp_err(m0_icb_rsp_err),
        .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
        .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
        .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
        .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
        .m1_icb_rsp_rdata(m1_icb_rsp_rdata), .m1_icb_rsp_err(m1_icb_rsp_err),
        .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
        .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
        .s_icb_rsp_rdata(s_icb_rsp_rdata), .s_icb_rsp_err(s_icb_rsp_err),
        .arb_active(arb_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_icb_cmd_valid = 0; m0_icb_cmd_addr = '0; m0_icb_cmd_read = 0;
        m0_icb_cmd_wdata = '0; m0_icb_cmd_wmask = '0; m0_icb_rsp_ready = 0;
        m1_icb_cmd_valid = 0; m1_icb_cmd_addr = '0; m1_icb_cmd_read = 0;
        m1_icb_cmd_wdata = '0; m1_icb_cmd_wmask = '0; m1_icb_rsp_ready = 0;
        s_icb_cmd_ready = 0; s_icb_rsp_valid = 0;
        s_icb_rsp_rdata = '0; s_icb_rsp_err = 0;
    endtask

    function automatic logic [6:0] outs();
        return {s_icb_cmd_valid, m0_icb_cmd_ready, m1_icb_cmd_ready,
                m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready, arb_active};
    endfunction

    task automatic test_reset();
        idle();
        rst_n = 0;
        #2;
        checks++; if (outs() !== 7'b0) begin errors++; $display("FAIL reset_outs got %b exp %b", outs(), 7'b0); end
        tick(); tick();
        rst_n = 1;
        tick(); tick();
        checks++; if (outs() !== 7'b0) begin errors++; $display("FAIL idle_outs got %b exp %b", outs(), 7'b0); end
    endtask

    task automatic test_contention();
        tick();
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h10; m0_icb_cmd_read = 1;
        m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h20; m1_icb_cmd_read = 1;
        s_icb_cmd_ready = 1;
        #1;
        checks++; if (s_icb_cmd_addr !== 32'h10) begin errors++; $display("FAIL cont_addr0 got %h exp %h", s_icb_cmd_addr, 32'h10); end
        checks++; if ({m0_icb_cmd_ready, m1_icb_cmd_ready, s_icb_cmd_read} !== 3'b101) begin errors++; $display("FAIL cont_rdy0 got %b exp 101", {m0_icb_cmd_ready, m1_icb_cmd_ready, s_icb_cmd_read}); end
        tick();
        #1;
        checks++; if (s_icb_cmd_addr !== 32'h20) begin errors++; $display("FAIL cont_addr1 got %h exp %h", s_icb_cmd_addr, 32'h20); end
        checks++; if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b01) begin errors++; $display("FAIL cont_rdy1 got %b exp 01", {m0_icb_cmd_ready, m1_icb_cmd_ready}); end
        tick();
        m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
        s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hA;
        m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
        #1;
        checks++; if ({m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready} !== 3'b101) begin errors++; $display("FAIL cont_rsp0 got %b exp 101", {m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready}); end
        checks++; if (m0_icb_rsp_rdata !== 32'hA) begin errors++; $display("FAIL cont_rdata0 got %h exp %h", m0_icb_rsp_rdata, 32'hA); end
        tick();
        s_icb_rsp_rdata = 32'hB;
        #1;
        checks++; if ({m0_icb_rsp_valid, m1_icb_rsp_valid} !== 2'b01) begin errors++; $display("FAIL cont_rsp1 got %b exp 01", {m0_icb_rsp_valid, m1_icb_rsp_valid}); end
        checks++; if (m1_icb_rsp_rdata !== 32'hB) begin errors++; $display("FAIL cont_rdata1 got %h exp %h", m1_icb_rsp_rdata, 32'hB); end
        tick();
        idle();
        #1;
        checks++; if (arb_active !== 1'b0) begin errors++; $display("FAIL cont_drained got %b exp 0", arb_active); end
    endtask

    task automatic test_lock();
        // one m0 transfer first so a plain tie would favour m1
        tick();
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h40; s_icb_cmd_ready = 1;
        tick();
        m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
        s_icb_rsp_valid = 1; m0_icb_rsp_ready = 1;
        tick();
        idle();
        tick();
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h100; m0_icb_cmd_read = 1;
        #1;
        checks++; if (s_icb_cmd_addr !== 32'h100) begin errors++; $display("FAIL lock_addr_c0 got %h exp %h", s_icb_cmd_addr, 32'h100); end
        tick();
        m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h200; m1_icb_cmd_read = 1;
        #1;
        checks++; if (s_icb_cmd_addr !== 32'h100) begin errors++; $display("FAIL lock_addr_c1 got %h exp %h", s_icb_cmd_addr, 32'h100); end
        tick();
        #1;
        checks++; if (s_icb_cmd_addr !== 32'h100) begin errors++; $display("FAIL lock_addr_c2 got %h exp %h", s_icb_cmd_addr, 32'h100); end
        tick();
        s_icb_cmd_ready = 1;
        #1;
        checks++; if (s_icb_cmd_addr !== 32'h100) begin errors++; $display("FAIL lock_addr_hs got %h exp %h", s_icb_cmd_addr, 32'h100); end
        checks++; if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b10) begin errors++; $display("FAIL lock_rdy_hs got %b exp 10", {m0_icb_cmd_ready, m1_icb_cmd_ready}); end
        tick();
        m0_icb_cmd_valid = 0;
        #1;
        checks++; if (s_icb_cmd_addr !== 32'h200 || m1_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL lock_m1_grant got addr %h rdy %b exp addr %h rdy 1", s_icb_cmd_addr, m1_icb_cmd_ready, 32'h200); end
        tick();
        m1_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
        s_icb_rsp_valid = 1; m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
        #1;
        checks++; if ({m0_icb_rsp_valid, m1_icb_rsp_valid} !== 2'b10) begin errors++; $display("FAIL lock_rsp0 got %b exp 10", {m0_icb_rsp_valid, m1_icb_rsp_valid}); end
        tick();
        #1;
        checks++; if ({m0_icb_rsp_valid, m1_icb_rsp_valid} !== 2'b01) begin errors++; $display("FAIL lock_rsp1 got %b exp 01", {m0_icb_rsp_valid, m1_icb_rsp_valid}); end
        tick();
        idle();
    endtask

    task automatic test_full();
        tick();
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h300; s_icb_cmd_ready = 1;
        tick();
        m0_icb_cmd_addr = 32'h304;
        tick();
        m0_icb_cmd_addr = 32'h308;
        #1;
        checks++; if ({s_icb_cmd_valid, m0_icb_cmd_ready} !== 2'b00) begin errors++; $display("FAIL full_block got %b exp 00", {s_icb_cmd_valid, m0_icb_cmd_ready}); end
        tick();
        s_icb_rsp_valid = 1; m0_icb_rsp_ready = 1;
        #1;
        checks++; if ({s_icb_rsp_ready, s_icb_cmd_valid} !== 2'b10) begin errors++; $display("FAIL full_nobypass got %b exp 10", {s_icb_rsp_ready, s_icb_cmd_valid}); end
        tick();
        s_icb_rsp_valid = 0;
        #1;
        checks++; if ({s_icb_cmd_valid, m0_icb_cmd_ready} !== 2'b11) begin errors++; $display("FAIL full_accept got %b exp 11", {s_icb_cmd_valid, m0_icb_cmd_ready}); end
        tick();
        m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
        #1;
        checks++; if (arb_active !== 1'b1) begin errors++; $display("FAIL full_active got %b exp 1", arb_active); end
        s_icb_rsp_valid = 1;
        tick(); tick();
        idle();
        #1;
        checks++; if (arb_active !== 1'b0) begin errors++; $display("FAIL full_drained got %b exp 0", arb_active); end
    endtask

    task automatic test_backpressure();
        tick();
        m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h400; s_icb_cmd_ready = 1;
        tick();
        m1_icb_cmd_valid = 0;
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h500;
        tick();
        m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
        s_icb_rsp_valid = 1; s_icb_rsp_err = 1; s_icb_rsp_rdata = 32'h55;
        m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 0;
        #1;
        checks++; if ({s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid} !== 3'b001) begin errors++; $display("FAIL bp_stall got %b exp 001", {s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid}); end
        tick();
        #1;
        checks++; if ({s_icb_rsp_ready, m1_icb_rsp_valid} !== 2'b01) begin errors++; $display("FAIL bp_hold got %b exp 01", {s_icb_rsp_ready, m1_icb_rsp_valid}); end
        m1_icb_rsp_ready = 1;
        #1;
        checks++; if ({s_icb_rsp_ready, m1_icb_rsp_err} !== 2'b11) begin errors++; $display("FAIL bp_release got %b exp 11", {s_icb_rsp_ready, m1_icb_rsp_err}); end
        tick();
        s_icb_rsp_valid = 0; s_icb_rsp_err = 0;
        #1;
        checks++; if ({m1_icb_rsp_valid, arb_active} !== 2'b01) begin errors++; $display("FAIL bp_single_pop got %b exp 01", {m1_icb_rsp_valid, arb_active}); end
        s_icb_rsp_valid = 1;
        #1;
        checks++; if ({m0_icb_rsp_valid, m1_icb_rsp_valid} !== 2'b10) begin errors++; $display("FAIL bp_next_head got %b exp 10", {m0_icb_rsp_valid, m1_icb_rsp_valid}); end
        tick();
        idle();
        #1;
        checks++; if (arb_active !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", arb_active); end
    endtask

    task automatic test_spurious();
        tick();
        s_icb_rsp_valid = 1; s_icb_rsp_err = 1;
        m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
        #1;
        checks++; if (outs() !== 7'b0) begin errors++; $display("FAIL spur_outs got %b exp %b", outs(), 7'b0); end
        tick();
        #1;
        checks++; if (outs() !== 7'b0) begin errors++; $display("FAIL spur_hold got %b exp %b", outs(), 7'b0); end
        idle();
    endtask

    task automatic test_reset_mid();
        tick();
        m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h600; s_icb_cmd_ready = 1;
        tick();
        m1_icb_cmd_valid = 0;
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h700;
        tick();
        m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
        s_icb_rsp_valid = 1; m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
        #1;
        checks++; if ({s_icb_rsp_ready, m1_icb_rsp_valid} !== 2'b11) begin errors++; $display("FAIL rst_pre got %b exp 11", {s_icb_rsp_ready, m1_icb_rsp_valid}); end
        rst_n = 0;
        #1;
        checks++; if (outs() !== 7'b0) begin errors++; $display("FAIL rst_async got %b exp %b", outs(), 7'b0); end
        tick();
        idle();
        rst_n = 1;
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h800;
        m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h900;
        s_icb_cmd_ready = 1;
        #1;
        checks++; if (s_icb_cmd_addr !== 32'h800 || m0_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_tie got addr %h rdy %b exp addr %h rdy 1", s_icb_cmd_addr, m0_icb_cmd_ready, 32'h800); end
        tick();
        idle();
    endtask

    task automatic test_random();
        int            q[$];
        int            last, lock, s, hd;
        bit            v[2], hold[2], rd[2], rr[2], emp, full, ev, hs;
        bit            er0, er1, erv0, erv1, esr, eact, sr, rv;
        logic [AW-1:0] a[2];
        logic [DW-1:0] wd[2];
        logic [DW-1:0] rdat;
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        last = 1; lock = -1;
        hold[0] = 0; hold[1] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!hold[i]) begin
                    v[i]  = ($urandom_range(0, 2) != 0);
                    a[i]  = $urandom;
                    wd[i] = $urandom;
                    rd[i] = $urandom_range(0, 1) == 1;
                end
            end
            sr    = ($urandom_range(0, 3) != 0);
            rv    = ($urandom_range(0, 1) == 1);
            rr[0] = ($urandom_range(0, 3) != 0);
            rr[1] = ($urandom_range(0, 3) != 0);
            rdat  = $urandom;
            m0_icb_cmd_valid = v[0]; m0_icb_cmd_addr = a[0];
            m0_icb_cmd_wdata = wd[0]; m0_icb_cmd_read = rd[0];
            m1_icb_cmd_valid = v[1]; m1_icb_cmd_addr = a[1];
            m1_icb_cmd_wdata = wd[1]; m1_icb_cmd_read = rd[1];
            s_icb_cmd_ready = sr; s_icb_rsp_valid = rv; s_icb_rsp_rdata = rdat;
            m0_icb_rsp_ready = rr[0]; m1_icb_rsp_ready = rr[1];
            #1;
            full = (q.size() == DEPTH);
            emp  = (q.size() == 0);
            if (lock >= 0) s = lock;
            else if (v[0] && !v[1]) s = 0;
            else if (v[1] && !v[0]) s = 1;
            else s = 1 - last;
            ev   = (v[0] || v[1]) && !full;
            hs   = ev && sr;
            er0  = (s == 0) && sr && !full;
            er1  = (s == 1) && sr && !full;
            hd   = emp ? 0 : q[0];
            erv0 = rv && !emp && (hd == 0);
            erv1 = rv && !emp && (hd == 1);
            esr  = !emp && rr[hd];
            eact = v[0] || v[1] || !emp;
            checks++;
            if (outs() !== {ev, er0, er1, erv0, erv1, esr, eact}) begin
                errors++;
                $display("FAIL rand_ctl cyc %0d got %b exp %b", c, outs(), {ev, er0, er1, erv0, erv1, esr, eact});
            end
            if (ev) begin
                checks++;
                if (s_icb_cmd_addr !== a[s] || s_icb_cmd_wdata !== wd[s] || s_icb_cmd_read !== rd[s]) begin
                    errors++;
                    $display("FAIL rand_cmd cyc %0d got %h/%h/%b exp %h/%h/%b", c, s_icb_cmd_addr, s_icb_cmd_wdata, s_icb_cmd_read, a[s], wd[s], rd[s]);
                end
            end
            if (erv0 || erv1) begin
                checks++;
                if ((erv0 ? m0_icb_rsp_rdata : m1_icb_rsp_rdata) !== rdat) begin
                    errors++;
                    $display("FAIL rand_rdata cyc %0d got %h exp %h", c, erv0 ? m0_icb_rsp_rdata : m1_icb_rsp_rdata, rdat);
                end
            end
            if (esr && rv) void'(q.pop_front());
            if (hs) begin
                q.push_back(s);
                last = s;
            end
            if (hs) lock = -1;
            else if (lock >= 0 && !v[lock]) lock = -1;
            else if (ev && !sr) lock = s;
            hold[0] = v[0] && !er0;
            hold[1] = v[1] && !er1;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_lock();
        test_full();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qpu_dtcm_icb_arbiter.md
# qpu_dtcm_icb_arbiter

Two-requester ICB arbiter placed in front of the QPU data TCM. It shares the single DTCM ICB port between the EXU load/store path (requester 0) and a host-side program/data loader (requester 1). Commands are granted round-robin, and a grant is held while a command stalls. Single-beat responses return in order and are routed back to the originator through a small outstanding-request FIFO.

## Interface
Parameters:
- AW, default `QPU_ADDR_SIZE`: address width.
- DW, default `QPU_XLEN`: data width; the mask width is DW/8.
- OUTS_DEPTH, default 2: maximum number of outstanding commands (legal values 1, 2 or 4).

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- m0_icb_cmd_valid / m0_icb_cmd_ready  in / out  1  EXU command handshake.
- m0_icb_cmd_addr  in  AW  EXU address.
- m0_icb_cmd_read  in  1  1 = read, 0 = write.
- m0_icb_cmd_wdata  in  DW  EXU write data.
- m0_icb_cmd_wmask  in  DW/8  EXU byte mask.
- m0_icb_rsp_valid / m0_icb_rsp_ready  out / in  1  EXU response handshake.
- m0_icb_rsp_rdata  out  DW  EXU read data.
- m0_icb_rsp_err  out  1  EXU response error.
- m1_icb_*  same set of ports with the same directions and widths: loader requester.
- s_icb_cmd_valid / s_icb_cmd_ready  out / in  1  DTCM command handshake.
- s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask  out  AW / 1 / DW / DW/8  command fields from the granted requester.
- s_icb_rsp_valid / s_icb_rsp_ready  in / out  1  DTCM response handshake.
- s_icb_rsp_rdata  in  DW  DTCM read data.
- s_icb_rsp_err  in  1  DTCM response error.
- arb_active  out  1  high when any cmd_valid is high or any command is outstanding; used for clock gating.

## Operation
- Command path is combinational; no command register.
- full = outstanding FIFO holds OUTS_DEPTH entries.
- s_icb_cmd_valid = (m0_cmd_valid | m1_cmd_valid) & !full.
- Selection, in priority order:
  - If the lock is set, the locked index is selected.
  - Else, if only one requester is valid, that requester is selected.
  - Else (both valid), the requester that is not rr_last is selected.
- s_icb_cmd_* fields are muxed from the selected requester.
- mX_cmd_ready = (sel == X) & s_icb_cmd_ready & !full. The non-selected requester sees ready = 0.
- rr_last register: updated to the granted index on every s_cmd handshake. Reset value is 1, so m0 wins the first tie.
- Lock register (lock_vld, lock_idx):
  - Set when s_icb_cmd_valid & !s_icb_cmd_ready; lock_idx takes sel.
  - Cleared on the s_cmd handshake.
  - Guarantees address, data and read are stable to the DTCM while valid is high.
  - If the locked requester drops valid (an ICB protocol violation), the lock clears on the next cycle.
- Outstanding FIFO:
  - Width 1 bit (requester index), depth OUTS_DEPTH.
  - Push on the s_cmd handshake; pop on the s_rsp handshake.
  - Push and pop in the same cycle leave the count unchanged.
  - Count width is clog2(OUTS_DEPTH)+1; read and write pointers wrap modulo OUTS_DEPTH.
- Response routing, with head = FIFO head index:
  - m[head]_rsp_valid = s_rsp_valid & !empty.
  - rdata and err are fanned to both requesters; only the valid qualifies them.
  - s_icb_rsp_ready = !empty & m[head]_rsp_ready.
- Response while the FIFO is empty: s_icb_rsp_ready stays 0, no requester sees valid, and the FIFO state is unchanged.

## Timing
- Reset values:
  - FIFO empty; rr_last = 1; lock_vld = 0.
  - All outputs 0: s_icb_cmd_valid, mX_cmd_ready, mX_rsp_valid, s_icb_rsp_ready and arb_active.
  - With no inputs asserted, all outputs stay 0 after reset.
- Command latency: 0 cycles, requester to DTCM.
- Response latency: 0 cycles, DTCM to requester.
- Arbitration adds no bubble: back-to-back grants on consecutive cycles are allowed, alternating under contention.
- When full, the FIFO is not bypassed by a same-cycle pop: s_cmd_valid is 0 for that cycle, and a command can be accepted on the next cycle.
- Reset mid-operation clears the FIFO and the lock asynchronously. Outstanding responses are dropped; the DTCM must be reset by the same reset.

## Test plan
- Contention:
  - Stimulus: after reset, m0 and m1 both hold a valid read (addr 0x10 and 0x20) with s_cmd_ready = 1.
  - Response: cycle 0 grants m0 (addr 0x10); cycle 1 grants m1 (addr 0x20).
  - DTCM responses with rdata 0xA and 0xB return 0xA to m0 and then 0xB to m1.
- Lock:
  - Stimulus: m0 valid, s_cmd_ready = 0 for 3 cycles; m1 raises valid in cycle 1.
  - Response: s_cmd_addr stays at m0's address for all 3 cycles; m1 is granted on the cycle after m0's handshake.
- Full FIFO (OUTS_DEPTH = 2):
  - Stimulus: two commands accepted with no response; a third command is pending.
  - Response: s_cmd_valid = 0 until the first response handshake, then the third command is accepted on the next cycle.
- Response backpressure:
  - Stimulus: head = m1, m1_rsp_ready = 0, s_rsp_valid = 1 with err = 1.
  - Response: s_rsp_ready = 0 and m0_rsp_valid = 0. When m1_rsp_ready rises, a single pop occurs and m1 sees err = 1.
- Spurious response:
  - Stimulus: s_rsp_valid = 1 with the FIFO empty.
  - Response: s_rsp_ready = 0, no mX_rsp_valid, and arb_active = 0.
- Reset:
  - Stimulus: rst_n asserted with 2 commands outstanding.
  - Response: all outputs go to 0 immediately; after release, m0 wins the first tie.
